// File: rtl/rs_issue_select.sv
// Reservation-station slice allocator + age-matrix oldest-ready issue select (optional RS_SELECT_PERF_EN perf counters).
// Latency: alloc_idx/issue_idx combinational from state; allocated entry issuable the next cycle, freed entry reusable the next cycle.
// Backpressure: fu_ready=0 holds the selected entry; full or flush deasserts alloc_ready; flush also deasserts issue_valid.
module rs_issue_select #(
    parameter  int RS_ENTRIES = 8,
    localparam int IDX_W      = $clog2(RS_ENTRIES),
    localparam int OCC_W      = $clog2(RS_ENTRIES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    output logic [IDX_W-1:0]      alloc_idx,
    input  logic [RS_ENTRIES-1:0] entry_ready,
    input  logic                  fu_ready,
    output logic                  issue_valid,
    output logic [IDX_W-1:0]      issue_idx,
    output logic [RS_ENTRIES-1:0] entry_valid,
`ifdef RS_SELECT_PERF_EN
    output logic [31:0]           stall_fu_cnt,
    output logic [31:0]           alloc_reject_cnt,
`endif
    output logic [OCC_W-1:0]      occupancy
);

    logic [RS_ENTRIES-1:0]                 valid_q, valid_d;
    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] age_q, age_d;
    logic [OCC_W-1:0]                      occ_q, occ_d;

    logic                  full;
    logic                  alloc_fire;
    logic                  issue_fire;
    logic [RS_ENTRIES-1:0] elig;
    logic [RS_ENTRIES-1:0] older_elig;
    logic [RS_ENTRIES-1:0] oldest;

    assign full        = (occ_q == OCC_W'(RS_ENTRIES));
    assign alloc_ready = ~full & ~flush;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign elig        = valid_q & entry_ready;
    assign issue_valid = (|elig) & ~flush;
    assign issue_fire  = issue_valid & fu_ready;
    assign entry_valid = valid_q;
    assign occupancy   = occ_q;

    always_comb begin
        alloc_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    // An eligible entry is the oldest when no other eligible entry is older than it.
    always_comb begin
        older_elig = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (j != i && elig[j] && age_q[j][i]) older_elig[i] = 1'b1;
            end
        end
    end

    assign oldest = elig & ~older_elig;

    always_comb begin
        issue_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (oldest[i]) issue_idx = IDX_W'(i);
        end
    end

    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        occ_d   = occ_q;
        if (flush) begin
            valid_d = '0;
            age_d   = '0;
            occ_d   = '0;
        end else begin
            if (issue_fire) valid_d[issue_idx] = 1'b0;
            if (alloc_fire) begin
                valid_d[alloc_idx] = 1'b1;
                age_d[alloc_idx]   = '0;
                // Every entry valid before this edge is older than the newcomer.
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    age_d[j][alloc_idx] = valid_q[j];
                end
            end
            case ({alloc_fire, issue_fire})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            age_q   <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
            occ_q   <= occ_d;
        end
    end

`ifdef RS_SELECT_PERF_EN
    logic [31:0] stall_q, reject_q;
    logic        stall_evt, reject_evt;

    assign stall_evt        = (|elig) & ~fu_ready & ~flush;
    assign reject_evt       = alloc_valid & full & ~flush;
    assign stall_fu_cnt     = stall_q;
    assign alloc_reject_cnt = reject_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q  <= '0;
            reject_q <= '0;
        end else begin
            if (stall_evt && stall_q != '1)   stall_q  <= stall_q + 32'd1;
            if (reject_evt && reject_q != '1) reject_q <= reject_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: age ordering, full, backpressure, simultaneous alloc/issue, flush and reset.
module tb_rs_issue_select;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [2:0] alloc_idx;
    logic [7:0] entry_ready;
    logic       fu_ready;
    logic       issue_valid;
    logic [2:0] issue_idx;
    logic [7:0] entry_valid;
    logic [3:0] occupancy;
`ifdef RS_SELECT_PERF_EN
    logic [31:0] stall_fu_cnt;
    logic [31:0] alloc_reject_cnt;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rs_issue_select #(.RS_ENTRIES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_idx   (alloc_idx),
        .entry_ready (entry_ready),
        .fu_ready    (fu_ready),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .entry_valid (entry_valid),
`ifdef RS_SELECT_PERF_EN
        .stall_fu_cnt     (stall_fu_cnt),
        .alloc_reject_cnt (alloc_reject_cnt),
`endif
        .occupancy   (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        flush       = 1'b0;
        alloc_valid = 1'b0;
        entry_ready = 8'h00;
        fu_ready    = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic do_alloc(input int n);
        alloc_valid = 1'b1;
        repeat (n) tick();
        alloc_valid = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_idx",   32'(alloc_idx),   32'd0);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_issue_idx",   32'(issue_idx),   32'd0);
        check("rst_entry_valid", 32'(entry_valid), 32'd0);
        check("rst_occupancy",   32'(occupancy),   32'd0);

        // Age ordering: allocate 0,1,2 then drain
        alloc_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("ord_alloc_idx", 32'(alloc_idx), 32'(k));
            tick();
        end
        alloc_valid = 1'b0;
        #1;
        check("ord_entry_valid", 32'(entry_valid), 32'h07);
        check("ord_occ3", 32'(occupancy), 32'd3);
        entry_ready = 8'hFF;
        fu_ready    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("ord_issue_valid", 32'(issue_valid), 32'd1);
            check("ord_issue_idx",   32'(issue_idx),   32'(k));
            tick();
        end
        check("ord_empty_issue_valid", 32'(issue_valid), 32'd0);
        check("ord_empty_occ", 32'(occupancy), 32'd0);
        fu_ready    = 1'b0;
        entry_ready = 8'h00;

        // Age beats index: entries 2,3 older than re-used 0,1
        do_reset();
        do_alloc(4);
        entry_ready = 8'hFF;
        fu_ready    = 1'b1;
        tick();
        tick();
        fu_ready = 1'b0;
        #1;
        check("abi_entry_valid", 32'(entry_valid), 32'h0C);
        alloc_valid = 1'b1;
        #1;
        check("abi_alloc_idx0", 32'(alloc_idx), 32'd0);
        tick();
        check("abi_alloc_idx1", 32'(alloc_idx), 32'd1);
        tick();
        alloc_valid = 1'b0;
        fu_ready    = 1'b1;
        begin
            logic [2:0] order [4];
            order = '{3'd2, 3'd3, 3'd0, 3'd1};
            for (int k = 0; k < 4; k++) begin
                #1;
                check("abi_issue_idx", 32'(issue_idx), 32'(order[k]));
                tick();
            end
        end
        check("abi_occ_end", 32'(occupancy), 32'd0);
        fu_ready    = 1'b0;
        entry_ready = 8'h00;

        // Full, with alloc_valid held 4 extra cycles while full
        do_reset();
        alloc_valid = 1'b1;
        repeat (8) tick();
        check("full_occ", 32'(occupancy), 32'd8);
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        check("full_entry_valid", 32'(entry_valid), 32'hFF);
        repeat (4) tick();
        alloc_valid = 1'b0;
        #1;
`ifdef RS_SELECT_PERF_EN
        check("perf_alloc_reject", alloc_reject_cnt, 32'd4);
`endif
        entry_ready = 8'h20;
        fu_ready    = 1'b1;
        #1;
        check("full_issue_idx", 32'(issue_idx), 32'd5);
        check("full_alloc_ready_issue_cycle", 32'(alloc_ready), 32'd0);
        tick();
        fu_ready = 1'b0;
        #1;
        check("full_after_alloc_ready", 32'(alloc_ready), 32'd1);
        check("full_after_alloc_idx",   32'(alloc_idx),   32'd5);
        check("full_after_occ",         32'(occupancy),   32'd7);

        // Backpressure: entries 2 and 4 left, 4 older
        do_reset();
        do_alloc(5);
        entry_ready = 8'h04;
        fu_ready    = 1'b1;
        tick();
        fu_ready    = 1'b0;
        entry_ready = 8'h00;
        #1;
        check("bp_realloc_idx", 32'(alloc_idx), 32'd2);
        do_alloc(1);
        entry_ready = 8'h0B;
        fu_ready    = 1'b1;
        repeat (3) tick();
        fu_ready    = 1'b0;
        entry_ready = 8'h14;
        #1;
        check("bp_entry_valid", 32'(entry_valid), 32'h14);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_issue_valid", 32'(issue_valid), 32'd1);
            check("bp_hold_issue_idx",   32'(issue_idx),   32'd4);
            check("bp_hold_occ",         32'(occupancy),   32'd2);
            tick();
        end
        fu_ready = 1'b1;
        #1;
        tick();
        fu_ready = 1'b0;
        #1;
        check("bp_freed_entry_valid", 32'(entry_valid), 32'h04);
        check("bp_freed_occ",         32'(occupancy),   32'd1);
        check("bp_next_issue_idx",    32'(issue_idx),   32'd2);
        entry_ready = 8'h00;

        // Simultaneous alloc + issue
        do_reset();
        do_alloc(3);
        alloc_valid = 1'b1;
        entry_ready = 8'h01;
        fu_ready    = 1'b1;
        #1;
        check("sim_alloc_idx", 32'(alloc_idx), 32'd3);
        check("sim_issue_idx", 32'(issue_idx), 32'd0);
        tick();
        alloc_valid = 1'b0;
        fu_ready    = 1'b0;
        entry_ready = 8'h00;
        #1;
        check("sim_occ",         32'(occupancy),   32'd3);
        check("sim_entry_valid", 32'(entry_valid), 32'h0E);

        // Flush mid-op
        do_reset();
        do_alloc(5);
        entry_ready = 8'hFF;
        fu_ready    = 1'b1;
        alloc_valid = 1'b1;
        flush       = 1'b1;
        #1;
        check("fl_alloc_ready", 32'(alloc_ready), 32'd0);
        check("fl_issue_valid", 32'(issue_valid), 32'd0);
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        fu_ready    = 1'b0;
        entry_ready = 8'h00;
        #1;
        check("fl_entry_valid", 32'(entry_valid), 32'h00);
        check("fl_occ",         32'(occupancy),   32'd0);
        check("fl_alloc_idx",   32'(alloc_idx),   32'd0);

        // Reset mid-op
        do_alloc(5);
        check("rm_pre_occ", 32'(occupancy), 32'd5);
        entry_ready = 8'hFF;
        fu_ready    = 1'b1;
        alloc_valid = 1'b1;
        rst         = 1'b0;
        tick();
        rst         = 1'b1;
        alloc_valid = 1'b0;
        fu_ready    = 1'b0;
        entry_ready = 8'h00;
        #1;
        check("rm_entry_valid", 32'(entry_valid), 32'h00);
        check("rm_occ",         32'(occupancy),   32'd0);
        check("rm_alloc_idx",   32'(alloc_idx),   32'd0);
        check("rm_alloc_ready", 32'(alloc_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
